// File: rtl/tl_tx_ecrc_gen.sv
// tl_tx_ecrc_gen: transmit-side End-to-End CRC generator.
// Accumulates CRC-32 (poly 0x04C11DB7, seed all-ones, MSB-first, no
// reflection, no final inversion) over the valid DWs of a TLP and appends
// the 1-DW digest after the last valid DW. If the last beat is full, one
// extra beat carries the digest.
// Optional build macro TL_TX_ECRC_ERR_INJ_EN adds i_ecrc_err_inj, which
// flips bit 0 of the emitted digest when set on the accepted EOP beat.
module tl_tx_ecrc_gen #(
    parameter int DW               = 32,
    parameter int VALID_DATA_WIDTH = 3,
    parameter int DATA_WIDTH       = 8 * DW,
    parameter int EP_BIT           = 22,
    parameter int ECRC_ON          = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cfg_ecrc_gen_en,
    output logic                        o_cfg_ecrc_gen_capable,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic [VALID_DATA_WIDTH-1:0] i_length,
    input  logic                        i_sop,
    input  logic                        i_eop,
    input  logic                        i_td,
`ifdef TL_TX_ECRC_ERR_INJ_EN
    input  logic                        i_ecrc_err_inj,
`endif
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic [VALID_DATA_WIDTH-1:0] o_length,
    output logic                        o_sop,
    output logic                        o_eop
);

    localparam int                        NUM_DW   = DATA_WIDTH / DW;
    localparam logic [31:0]               CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0]               CRC_SEED = 32'hFFFF_FFFF;
    localparam logic [VALID_DATA_WIDTH-1:0] LEN_ONE = {{(VALID_DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [VALID_DATA_WIDTH-1:0] LEN_MAX = {VALID_DATA_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_PASS  = 1'b0,
        ST_EXTRA = 1'b1
    } state_t;

    // Bit-serial CRC over the top (len+1) DWs of a beat, MSB first.
    function automatic logic [31:0] crc_update(
        input logic [31:0]                 seed,
        input logic [DATA_WIDTH-1:0]       data,
        input logic [VALID_DATA_WIDTH-1:0] len
    );
        logic [31:0] c;
        logic        fb;
        int          nbits;
        c     = seed;
        nbits = (int'(len) + 1) * DW;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < nbits) begin
                fb = c[31] ^ data[DATA_WIDTH-1-i];
                c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // Keeps DW slots 0..len, writes the digest into slot len+1, zeroes the rest.
    function automatic logic [DATA_WIDTH-1:0] insert_digest(
        input logic [DATA_WIDTH-1:0]       data,
        input logic [VALID_DATA_WIDTH-1:0] len,
        input logic [31:0]                 digest
    );
        logic [DATA_WIDTH-1:0] r;
        r = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_DW; k++) begin
            if (k <= int'(len)) begin
                r[DATA_WIDTH-1-k*DW -: DW] = data[DATA_WIDTH-1-k*DW -: DW];
            end else if (k == int'(len) + 1) begin
                r[DATA_WIDTH-1-k*DW -: DW] = digest;
            end else begin
                r[DATA_WIDTH-1-k*DW -: DW] = {DW{1'b0}};
            end
        end
        return r;
    endfunction

    state_t                state_r;
    logic                  gen_r;
    logic [31:0]           crc_r;
    logic [31:0]           digest_r;

    logic                  free_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  gen_eff_s;
    logic                  inj_s;
    logic [31:0]           seed_s;
    logic [31:0]           crc_next_s;
    logic [31:0]           digest_s;
    logic [DATA_WIDTH-1:0] crc_in_s;

`ifdef TL_TX_ECRC_ERR_INJ_EN
    assign inj_s = i_ecrc_err_inj;
`else
    assign inj_s = 1'b0;
`endif

    assign o_cfg_ecrc_gen_capable = (ECRC_ON != 0);
    assign free_s   = ~o_valid | i_ready;
    assign ready_s  = free_s & (state_r == ST_PASS);
    assign o_ready  = ready_s;
    assign accept_s = i_valid & ready_s;

    // CRC input path: EP bit masked on SOP, seed restarts on SOP, digest with optional flip.
    always_comb begin
        crc_in_s = i_data;
        if (i_sop) begin
            crc_in_s[EP_BIT] = 1'b0;
            gen_eff_s        = i_td & i_cfg_ecrc_gen_en;
            seed_s           = CRC_SEED;
        end else begin
            gen_eff_s = gen_r;
            seed_s    = crc_r;
        end
        crc_next_s = crc_update(seed_s, crc_in_s, i_length);
        digest_s   = crc_next_s ^ {31'b0, inj_s};
    end

    // Output stage, CRC accumulator and PASS/EXTRA sequencing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_PASS;
            gen_r    <= 1'b0;
            crc_r    <= CRC_SEED;
            digest_r <= 32'h0000_0000;
            o_valid  <= 1'b0;
            o_data   <= {DATA_WIDTH{1'b0}};
            o_length <= {VALID_DATA_WIDTH{1'b0}};
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
        end else begin
            case (state_r)
                ST_PASS: begin
                    if (accept_s) begin
                        o_valid <= 1'b1;
                        o_sop   <= i_sop;
                        gen_r   <= i_eop ? 1'b0 : gen_eff_s;
                        if (gen_eff_s) begin
                            crc_r <= i_eop ? CRC_SEED : crc_next_s;
                        end else begin
                            crc_r <= crc_r;
                        end
                        if (gen_eff_s && i_eop && (i_length != LEN_MAX)) begin
                            o_data   <= insert_digest(i_data, i_length, digest_s);
                            o_length <= i_length + LEN_ONE;
                            o_eop    <= 1'b1;
                        end else if (gen_eff_s && i_eop) begin
                            // Full last beat: digest goes out in a follow-up beat.
                            o_data   <= i_data;
                            o_length <= i_length;
                            o_eop    <= 1'b0;
                            digest_r <= digest_s;
                            state_r  <= ST_EXTRA;
                        end else begin
                            o_data   <= i_data;
                            o_length <= i_length;
                            o_eop    <= i_eop;
                        end
                    end else if (free_s) begin
                        o_valid <= 1'b0;
                    end else begin
                        o_valid <= o_valid;
                    end
                end
                ST_EXTRA: begin
                    if (free_s) begin
                        o_valid  <= 1'b1;
                        o_data   <= {digest_r, {(DATA_WIDTH-32){1'b0}}};
                        o_length <= {VALID_DATA_WIDTH{1'b0}};
                        o_sop    <= 1'b0;
                        o_eop    <= 1'b1;
                        state_r  <= ST_PASS;
                    end else begin
                        state_r <= ST_EXTRA;
                    end
                end
                default: begin
                    state_r <= ST_PASS;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_tx_ecrc_gen.sv
// Self-checking bench for tl_tx_ecrc_gen: directed TLPs, output scoreboard,
// CRC reference model and zero-residue check on generated digests.
module tb_tl_tx_ecrc_gen;

    localparam int DWID = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_en;
    logic            cap_o;
    logic            i_valid;
    logic            o_ready;
    logic [DWID-1:0] i_data;
    logic [2:0]      i_length;
    logic            i_sop;
    logic            i_eop;
    logic            i_td;
    logic            o_valid;
    logic            i_ready;
    logic [DWID-1:0] o_data;
    logic [2:0]      o_length;
    logic            o_sop;
    logic            o_eop;
`ifdef TL_TX_ECRC_ERR_INJ_EN
    logic            err_inj = 1'b0;
`endif

    tl_tx_ecrc_gen dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_cfg_ecrc_gen_en      (cfg_en),
        .o_cfg_ecrc_gen_capable (cap_o),
        .i_valid                (i_valid),
        .o_ready                (o_ready),
        .i_data                 (i_data),
        .i_length               (i_length),
        .i_sop                  (i_sop),
        .i_eop                  (i_eop),
        .i_td                   (i_td),
`ifdef TL_TX_ECRC_ERR_INJ_EN
        .i_ecrc_err_inj         (err_inj),
`endif
        .o_valid                (o_valid),
        .i_ready                (i_ready),
        .o_data                 (o_data),
        .o_length               (o_length),
        .o_sop                  (o_sop),
        .o_eop                  (o_eop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DWID-1:0] cap_data[$];
    logic [4:0]      cap_ctl[$];
    logic [DWID-1:0] exp_data[$];
    logic [4:0]      exp_ctl[$];
    logic [DWID-1:0] last_cap;

    task automatic check_eq(input string tag, input logic [DWID-1:0] got, input logic [DWID-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference CRC: one DW, MSB first, poly 0x04C11DB7.
    function automatic logic [31:0] crc_dw(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C1_1DB7;
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_beat(input logic [31:0] c, input logic [DWID-1:0] beat,
                                             input int len, input logic sop);
        logic [DWID-1:0] b;
        logic [31:0]     r;
        b = beat;
        if (sop) b[22] = 1'b0;
        r = c;
        for (int k = 0; k <= len; k++) r = crc_dw(r, b[DWID-1-32*k -: 32]);
        return r;
    endfunction

    // Record every output transfer (handshake is decided by the levels seen here).
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            cap_data.push_back(o_data);
            cap_ctl.push_back({o_length, o_sop, o_eop});
        end
    end

    task automatic expect_beat(input logic [DWID-1:0] d, input logic [2:0] len, input logic sop, input logic eop);
        exp_data.push_back(d);
        exp_ctl.push_back({len, sop, eop});
    endtask

    task automatic send_beat(input logic [DWID-1:0] d, input logic [2:0] len,
                             input logic sop, input logic eop, input logic td);
        bit ok;
        @(posedge clk);
        #1;
        i_valid  = 1'b1;
        i_data   = d;
        i_length = len;
        i_sop    = sop;
        i_eop    = eop;
        i_td     = td;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (cap_data.size() < exp_data.size() && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_out(input string tag);
        int n;
        check_eq({tag, "_nbeats"}, 256'(cap_data.size()), 256'(exp_data.size()));
        n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s_data%0d", tag, k), cap_data[k], exp_data[k]);
            check_eq($sformatf("%s_ctl%0d", tag, k), 256'(cap_ctl[k]), 256'(exp_ctl[k]));
        end
        last_cap = (cap_data.size() > 0) ? cap_data[cap_data.size()-1] : '0;
        cap_data.delete();
        cap_ctl.delete();
        exp_data.delete();
        exp_ctl.delete();
    endtask

    task automatic run_t1(input string tag);
        logic [DWID-1:0] beat;
        logic [DWID-1:0] first;
        logic [31:0]     crc;
        logic [31:0]     res;
        beat = {32'h4000_0001, 32'h0000_000F, 32'hDEAD_BEEF, 160'h0};
        crc  = crc_beat(32'hFFFF_FFFF, beat, 2, 1'b1);
        expect_beat({32'h4000_0001, 32'h0000_000F, 32'hDEAD_BEEF, crc, 128'h0}, 3'd3, 1'b1, 1'b1);
        send_beat(beat, 3'd2, 1'b1, 1'b1, 1'b1);
        wait_out();
        if (cap_data.size() > 0) begin
            first = cap_data[0];
            res   = 32'hFFFF_FFFF;
            for (int k = 0; k < 4; k++) res = crc_dw(res, first[DWID-1-32*k -: 32]);
            check_eq({tag, "_residue"}, 256'(res), 256'(0));
        end
        compare_out(tag);
    endtask

    logic [DWID-1:0] b0, b1, b2, bb;
    logic [31:0]     crc, t2_dig, dig_a;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_en = 1'b1; i_valid = 1'b0; i_data = '0; i_length = 3'd0;
        i_sop = 1'b0; i_eop = 1'b0; i_td = 1'b0; i_ready = 1'b1;
        b0 = {32'h4000_0007, 32'h0100_00FF, 32'h1111_2222, 32'h3333_4444,
              32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA, 32'h1240_5678};
        b1 = {32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0001, 32'h8000_0000,
              32'hFFFF_FFFF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
        b2 = {32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h1234_5678, 32'h9ABC_DEF0,
              32'h0000_0000, 32'hFEDC_BA98, 32'h7654_3210, 32'hBEEF_CAFE};
        crc = crc_beat(32'hFFFF_FFFF, b0, 7, 1'b1);
        crc = crc_beat(crc, b1, 7, 1'b0);
        crc = crc_beat(crc, b2, 7, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_o_valid", 256'(o_valid), 256'(0));
        check_eq("rst_o_data", o_data, 256'(0));
        check_eq("rst_o_ctl", 256'({o_length, o_sop, o_eop}), 256'(0));
        check_eq("rst_o_ready", 256'(o_ready), 256'(1));
        check_eq("capable", 256'(cap_o), 256'(1));

        // T1: single beat, 3 DWs, digest in slot 3
        run_t1("t1");

        // T2: 3 full beats, digest in an extra beat
        expect_beat(b0, 3'd7, 1'b1, 1'b0);
        expect_beat(b1, 3'd7, 1'b0, 1'b0);
        expect_beat(b2, 3'd7, 1'b0, 1'b0);
        expect_beat({crc, 224'h0}, 3'd0, 1'b0, 1'b1);
        send_beat(b0, 3'd7, 1'b1, 1'b0, 1'b1);
        send_beat(b1, 3'd7, 1'b0, 1'b0, 1'b1);
        send_beat(b2, 3'd7, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_eq("t2_ready_low", 256'(o_ready), 256'(0));
        @(negedge clk);
        check_eq("t2_ready_back", 256'(o_ready), 256'(1));
        wait_out();
        compare_out("t2");
        t2_dig = last_cap[255:224];

        // T3: generation disabled by config, then by TD=0: pure pass-through
        for (int mode = 0; mode < 2; mode++) begin
            cfg_en = (mode == 1);
            expect_beat(b0, 3'd7, 1'b1, 1'b0);
            expect_beat(b1, 3'd7, 1'b0, 1'b0);
            expect_beat(b2, 3'd7, 1'b0, 1'b1);
            send_beat(b0, 3'd7, 1'b1, 1'b0, (mode == 0));
            @(negedge clk);
            check_eq($sformatf("t3_latency_m%0d", mode), {255'(0), o_valid} & 256'(o_data == b0), 256'(1));
            send_beat(b1, 3'd7, 1'b0, 1'b0, (mode == 0));
            send_beat(b2, 3'd7, 1'b0, 1'b1, (mode == 0));
            wait_out();
            compare_out($sformatf("t3_m%0d", mode));
        end
        cfg_en = 1'b1;

        // T4: EP bit does not affect the digest but is transmitted
        expect_beat(b0, 3'd7, 1'b1, 1'b0);
        expect_beat({crc_beat(32'hFFFF_FFFF, b0, 7, 1'b1), 224'h0}, 3'd0, 1'b0, 1'b1);
        send_beat(b0, 3'd7, 1'b1, 1'b1, 1'b1);
        wait_out();
        if (cap_data.size() > 0) begin
            bb = cap_data[0];
            check_eq("t4_ep_sent", 256'(bb[22]), 256'(1));
        end
        compare_out("t4a");
        dig_a = last_cap[255:224];
        bb = b0;
        bb[22] = 1'b0;
        expect_beat(bb, 3'd7, 1'b1, 1'b0);
        expect_beat({crc_beat(32'hFFFF_FFFF, bb, 7, 1'b1), 224'h0}, 3'd0, 1'b0, 1'b1);
        send_beat(bb, 3'd7, 1'b1, 1'b1, 1'b1);
        wait_out();
        compare_out("t4b");
        check_eq("t4_ep_digest_same", 256'(last_cap[255:224]), 256'(dig_a));

        // T5: downstream stall mid-TLP
        expect_beat(b0, 3'd7, 1'b1, 1'b0);
        expect_beat(b1, 3'd7, 1'b0, 1'b0);
        expect_beat(b2, 3'd7, 1'b0, 1'b0);
        expect_beat({crc, 224'h0}, 3'd0, 1'b0, 1'b1);
        send_beat(b0, 3'd7, 1'b1, 1'b0, 1'b1);
        i_ready = 1'b0;
        fork
            send_beat(b1, 3'd7, 1'b0, 1'b0, 1'b1);
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check_eq($sformatf("t5_hold_valid%0d", c), 256'(o_valid), 256'(1));
                    check_eq($sformatf("t5_hold_data%0d", c), o_data, b0);
                    check_eq($sformatf("t5_hold_ready%0d", c), 256'(o_ready), 256'(0));
                end
                @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        send_beat(b2, 3'd7, 1'b0, 1'b1, 1'b1);
        wait_out();
        compare_out("t5");
        check_eq("t5_digest_vs_nostall", 256'(last_cap[255:224]), 256'(t2_dig));

        // T6: reset while waiting to emit the extra digest beat
        send_beat(b1, 3'd7, 1'b1, 1'b1, 1'b1);
        i_ready = 1'b0;
        @(negedge clk);
        check_eq("t6_ready_extra", 256'(o_ready), 256'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_valid", 256'(o_valid), 256'(0));
        check_eq("t6_rst_ready", 256'(o_ready), 256'(1));
        @(posedge clk);
        #1 i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_no_output", 256'(cap_data.size()), 256'(0));
        cap_data.delete();
        cap_ctl.delete();
        run_t1("t6_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
